perf_counters: RTL

Performance-monitor unit instantiated inside top. It owns the cycle, retired-instruction, stall, I-cache-stall, branch and branch-mispredict counters that top exports to the bench. It also provides a registered, selectable read port for debug and CSR-style access. It takes single-cycle event strobes from the datapath (WB retire, hazard unit, I-cache, branch resolution in ID) and produces the counter values that the bench reads.

---
 rtl/perf_counters.sv | 71 +++++++
 1 files changed

// File: rtl/perf_counters.sv
// perf_counters: six event counters with sticky wrap flags and a registered select-read port.
module perf_counters #(
    parameter int WIDTH   = 32,
    parameter int NUM_CNT = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               count_en,
    input  logic               freeze,
    input  logic               clear,
    input  logic               retire_valid,
    input  logic               stall,
    input  logic               icache_stall,
    input  logic               branch_resolved,
    input  logic               branch_mispredict,
    output logic [WIDTH-1:0]   cycle_count,
    output logic [WIDTH-1:0]   instruction_count,
    output logic [WIDTH-1:0]   stall_count,
    output logic [WIDTH-1:0]   icache_stall_count,
    output logic [WIDTH-1:0]   branch_count,
    output logic [WIDTH-1:0]   branch_mispredicts,
    output logic [NUM_CNT-1:0] overflow,
    input  logic               rd_req,
    input  logic [2:0]         rd_sel,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data
);
    logic [WIDTH-1:0]   cnt [NUM_CNT];
    logic [NUM_CNT-1:0] inc;
    logic [WIDTH-1:0]   sel_data;
    logic               active;

    always_comb begin
        inc    = {branch_resolved & branch_mispredict, branch_resolved, icache_stall, stall, retire_valid, 1'b1};
        active = count_en & ~freeze;
        sel_data = '0;
        for (int i = 0; i < NUM_CNT; i++)
            sel_data = (rd_sel == 3'(i)) ? cnt[i] : sel_data;
    end

    // reads sample pre-edge counter state, so a read alongside clear sees the old value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
            overflow <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rd_data <= sel_data;
            if (clear) begin
                for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
                overflow <= '0;
            end else if (active) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (inc[i]) begin
                        cnt[i] <= cnt[i] + 1'b1;
                        if (&cnt[i]) overflow[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign cycle_count        = cnt[0];
    assign instruction_count  = cnt[1];
    assign stall_count        = cnt[2];
    assign icache_stall_count = cnt[3];
    assign branch_count       = cnt[4];
    assign branch_mispredicts = cnt[5];
endmodule
